// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard bubbling, stall hold and flush squash; 1-cycle latency.
// Optional macro ID_EX_FWD_EN: bypass writeback data into ex_a/ex_b on load.
module id_ex_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [31:0] id_a,
    input  logic [31:0] id_b,
    input  logic [31:0] id_imm,
    input  logic [31:0] id_pc4,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [1:0]  id_wb_ctl,
    input  logic [2:0]  id_m_ctl,
    input  logic [3:0]  id_ex_ctl,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        ex_valid,
    output logic [31:0] ex_a,
    output logic [31:0] ex_b,
    output logic [31:0] ex_imm,
    output logic [31:0] ex_pc4,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_rd,
    output logic [1:0]  ex_wb_ctl,
    output logic [2:0]  ex_m_ctl,
    output logic [3:0]  ex_ex_ctl,
    output logic        hazard_stall,
    output logic [15:0] bubble_cnt
);

    logic        r_valid;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_imm;
    logic [31:0] r_pc4;
    logic [4:0]  r_rs;
    logic [4:0]  r_rt;
    logic [4:0]  r_rd;
    logic [1:0]  r_wb_ctl;
    logic [2:0]  r_m_ctl;
    logic [3:0]  r_ex_ctl;
    logic [15:0] r_bubble_cnt;

    logic        w_hazard;
    logic        w_take;
    logic        w_update;
    logic [31:0] w_a_nxt;
    logic [31:0] w_b_nxt;

`ifdef ID_EX_FWD_EN
    // Register file writes and reads in the same cycle; bypass closes that gap.
    assign w_a_nxt = (wb_regwrite && wb_rd != 5'd0 && wb_rd == id_rs) ? wb_data : id_a;
    assign w_b_nxt = (wb_regwrite && wb_rd != 5'd0 && wb_rd == id_rt) ? wb_data : id_b;
`else
    logic w_unused_wb;
    assign w_unused_wb = &{1'b0, wb_regwrite, wb_rd, wb_data};
    assign w_a_nxt     = id_a;
    assign w_b_nxt     = id_b;
`endif

    assign w_hazard = id_valid & r_valid & r_m_ctl[1] & (r_rt != 5'd0) &
                      ((r_rt == id_rs) | (r_rt == id_rt));

    // Flush overrides stall; anything not taken becomes an all-zero bubble.
    assign w_update = flush | ~stall;
    assign w_take   = ~flush & ~w_hazard & id_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_imm        <= '0;
            r_pc4        <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_wb_ctl     <= '0;
            r_m_ctl      <= '0;
            r_ex_ctl     <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_update) begin
                r_valid  <= w_take;
                r_a      <= w_take ? w_a_nxt   : '0;
                r_b      <= w_take ? w_b_nxt   : '0;
                r_imm    <= w_take ? id_imm    : '0;
                r_pc4    <= w_take ? id_pc4    : '0;
                r_rs     <= w_take ? id_rs     : '0;
                r_rt     <= w_take ? id_rt     : '0;
                r_rd     <= w_take ? id_rd     : '0;
                r_wb_ctl <= w_take ? id_wb_ctl : '0;
                r_m_ctl  <= w_take ? id_m_ctl  : '0;
                r_ex_ctl <= w_take ? id_ex_ctl : '0;
            end
            if (!flush && !stall && w_hazard && r_bubble_cnt != 16'hFFFF)
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign ex_valid     = r_valid;
    assign ex_a         = r_a;
    assign ex_b         = r_b;
    assign ex_imm       = r_imm;
    assign ex_pc4       = r_pc4;
    assign ex_rs        = r_rs;
    assign ex_rt        = r_rt;
    assign ex_rd        = r_rd;
    assign ex_wb_ctl    = r_wb_ctl;
    assign ex_m_ctl     = r_m_ctl;
    assign ex_ex_ctl    = r_ex_ctl;
    assign hazard_stall = w_hazard;
    assign bubble_cnt   = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, id_valid;
    logic [31:0] id_a, id_b, id_imm, id_pc4;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [1:0]  id_wb_ctl;
    logic [2:0]  id_m_ctl;
    logic [3:0]  id_ex_ctl;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        ex_valid;
    logic [31:0] ex_a, ex_b, ex_imm, ex_pc4;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [1:0]  ex_wb_ctl;
    logic [2:0]  ex_m_ctl;
    logic [3:0]  ex_ex_ctl;
    logic        hazard_stall;
    logic [15:0] bubble_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_a(id_a), .id_b(id_b), .id_imm(id_imm), .id_pc4(id_pc4),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_wb_ctl(id_wb_ctl), .id_m_ctl(id_m_ctl), .id_ex_ctl(id_ex_ctl),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_pc4(ex_pc4),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_wb_ctl(ex_wb_ctl), .ex_m_ctl(ex_m_ctl), .ex_ex_ctl(ex_ex_ctl),
        .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [2:0] m);
        id_valid = v; id_a = a; id_b = b; id_rs = rs; id_rt = rt; id_rd = rd; id_m_ctl = m;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; id_valid = 1'b0;
        id_a = '0; id_b = '0; id_imm = '0; id_pc4 = '0;
        id_rs = '0; id_rt = '0; id_rd = '0;
        id_wb_ctl = '0; id_m_ctl = '0; id_ex_ctl = '0;
        wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0;

        #12;
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_cnt", {16'd0, bubble_cnt}, 32'd0);
        chk("rst_hazard", {31'd0, hazard_stall}, 32'd0);
        rst_n = 1'b1;

        // Plain load
        set_id(1'b1, 32'h11, 32'h22, 5'd1, 5'd2, 5'd5, 3'b000);
        id_wb_ctl = 2'b10; id_imm = 32'h33; id_pc4 = 32'h104; id_ex_ctl = 4'b1100;
        edge1();
        chk("ld_valid", {31'd0, ex_valid}, 32'd1);
        chk("ld_a", ex_a, 32'h11);
        chk("ld_b", ex_b, 32'h22);
        chk("ld_rd", {27'd0, ex_rd}, 32'd5);
        chk("ld_wb", {30'd0, ex_wb_ctl}, 32'd2);
        chk("ld_imm", ex_imm, 32'h33);
        chk("ld_pc4", ex_pc4, 32'h104);
        chk("ld_exctl", {28'd0, ex_ex_ctl}, 32'hC);

        // Asynchronous reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, ex_valid}, 32'd0);
        chk("arst_a", ex_a, 32'd0);
        chk("arst_rd", {27'd0, ex_rd}, 32'd0);
        chk("arst_wb", {30'd0, ex_wb_ctl}, 32'd0);
        rst_n = 1'b1;
        id_valid = 1'b0;
        edge1();
        chk("idle_valid", {31'd0, ex_valid}, 32'd0);

        // Load-use: lw $8 in EX, consumer reads $8 as rs
        set_id(1'b1, 32'h1, 32'h2, 5'd9, 5'd8, 5'd0, 3'b010);
        id_wb_ctl = 2'b11; id_ex_ctl = 4'b0001;
        edge1();
        chk("lw_mctl", {29'd0, ex_m_ctl}, 32'b010);
        set_id(1'b1, 32'h44, 32'h55, 5'd8, 5'd10, 5'd11, 3'b000);
        id_wb_ctl = 2'b10; id_ex_ctl = 4'b1100;
        #1;
        chk("lu_hazard", {31'd0, hazard_stall}, 32'd1);
        edge1();
        chk("lu_bub_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bub_mctl", {29'd0, ex_m_ctl}, 32'd0);
        chk("lu_bub_wb", {30'd0, ex_wb_ctl}, 32'd0);
        chk("lu_bub_a", ex_a, 32'd0);
        chk("lu_cnt1", {16'd0, bubble_cnt}, 32'd1);
        chk("lu_hazard_drop", {31'd0, hazard_stall}, 32'd0);
        edge1();
        chk("lu_cons_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_cons_rs", {27'd0, ex_rs}, 32'd8);
        chk("lu_cons_a", ex_a, 32'h44);

        // Load to $0 never hazards
        set_id(1'b1, 32'h0, 32'h0, 5'd3, 5'd0, 5'd0, 3'b010);
        edge1();
        set_id(1'b1, 32'h66, 32'h0, 5'd0, 5'd0, 5'd12, 3'b000);
        #1;
        chk("zero_hazard", {31'd0, hazard_stall}, 32'd0);
        edge1();
        chk("zero_valid", {31'd0, ex_valid}, 32'd1);
        chk("zero_cnt", {16'd0, bubble_cnt}, 32'd1);

        // Stall holds a loaded lw even while a hazard is pending, then flush wins
        set_id(1'b1, 32'hAA, 32'hAB, 5'd4, 5'd8, 5'd0, 3'b010);
        edge1();
        stall = 1'b1;
        set_id(1'b1, 32'hBB, 32'hBC, 5'd8, 5'd1, 5'd2, 3'b000);
        for (int i = 0; i < 3; i++) begin
            chk("st_hazard", {31'd0, hazard_stall}, 32'd1);
            edge1();
            chk("st_a", ex_a, 32'hAA);
            chk("st_mctl", {29'd0, ex_m_ctl}, 32'b010);
            chk("st_cnt", {16'd0, bubble_cnt}, 32'd1);
        end
        stall = 1'b0; flush = 1'b1;
        edge1();
        chk("fl_valid", {31'd0, ex_valid}, 32'd0);
        chk("fl_a", ex_a, 32'd0);
        chk("fl_cnt", {16'd0, bubble_cnt}, 32'd1);
        flush = 1'b0;

        // Stall with hazard, then release inserts exactly one bubble
        set_id(1'b1, 32'hC0, 32'hC1, 5'd4, 5'd8, 5'd0, 3'b010);
        edge1();
        stall = 1'b1;
        set_id(1'b1, 32'hD0, 32'hD1, 5'd8, 5'd1, 5'd2, 3'b000);
        edge1();
        edge1();
        chk("sh_a", ex_a, 32'hC0);
        chk("sh_cnt", {16'd0, bubble_cnt}, 32'd1);
        stall = 1'b0;
        edge1();
        chk("sh_bub_valid", {31'd0, ex_valid}, 32'd0);
        chk("sh_cnt2", {16'd0, bubble_cnt}, 32'd2);
        edge1();
        chk("sh_cons_a", ex_a, 32'hD0);
        chk("sh_cnt_once", {16'd0, bubble_cnt}, 32'd2);

        // id_valid = 0 gives a bubble
        id_valid = 1'b0;
        edge1();
        chk("iv0_valid", {31'd0, ex_valid}, 32'd0);
        chk("iv0_pc4", ex_pc4, 32'd0);

        // Saturation: preload counter near the top, then keep bubbling
        force dut.r_bubble_cnt = 16'hFFFD;
        #1;
        release dut.r_bubble_cnt;
        set_id(1'b1, 32'h0, 32'h0, 5'd8, 5'd8, 5'd0, 3'b010);
        edge1();
        edge1();
        chk("sat_fffe", {16'd0, bubble_cnt}, 32'hFFFE);
        edge1();
        edge1();
        chk("sat_ffff", {16'd0, bubble_cnt}, 32'hFFFF);
        edge1();
        edge1();
        chk("sat_hold", {16'd0, bubble_cnt}, 32'hFFFF);

        // Writeback bypass
        set_id(1'b1, 32'h0, 32'h5, 5'd3, 5'd4, 5'd6, 3'b000);
        wb_regwrite = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD;
        edge1();
`ifdef ID_EX_FWD_EN
        chk("fwd_a", ex_a, 32'hDEAD);
`else
        chk("fwd_a", ex_a, 32'h0);
`endif
        chk("fwd_b_untouched", ex_b, 32'h5);
        wb_rd = 5'd0;
        edge1();
        chk("fwd_r0_a", ex_a, 32'h0);
        wb_rd = 5'd4;
        edge1();
        chk("fwd_rt_a", ex_a, 32'h0);
`ifdef ID_EX_FWD_EN
        chk("fwd_rt_b", ex_b, 32'hDEAD);
`else
        chk("fwd_rt_b", ex_b, 32'h5);
`endif
        wb_regwrite = 1'b0;
        edge1();
        chk("fwd_off_b", ex_b, 32'h5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage that sits directly downstream of the register file in the five-stage MIPS pipeline. It latches the register-file read ports (A, B), the decoded immediate, the register specifiers and the control bundles into the execute stage. It detects load-use hazards and inserts bubbles, honours downstream stall and branch flush, and keeps a saturating count of inserted hazard bubbles.

## Interface
- No parameters; all widths are fixed (32-bit datapath, 5-bit register specifiers).
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `stall` in 1: downstream hold request; the stage keeps its contents.
- `flush` in 1: branch/jump squash; the stage becomes a bubble.
- `id_valid` in 1: the ID-stage instruction is real (0 = bubble).
- `id_a`, `id_b` in 32: register-file read data for rs and rt.
- `id_imm` in 32: sign-extended immediate.
- `id_pc4` in 32: PC+4 of the instruction.
- `id_rs`, `id_rt`, `id_rd` in 5: register specifiers.
- `id_wb_ctl` in 2: {regwrite, memtoreg}.
- `id_m_ctl` in 3: {branch, memread, memwrite}.
- `id_ex_ctl` in 4: {regdst, aluop[1:0], alusrc}.
- `wb_regwrite` in 1, `wb_rd` in 5, `wb_data` in 32: writeback port; used only with forwarding compiled in.
- `ex_valid` out 1, plus `ex_a`, `ex_b`, `ex_imm`, `ex_pc4`, `ex_rs`, `ex_rt`, `ex_rd`, `ex_wb_ctl`, `ex_m_ctl`, `ex_ex_ctl` out: registered copies, with the same widths as their `id_` inputs.
- `hazard_stall` out 1: combinational; stall PC and IF/ID this cycle.
- `bubble_cnt` out 16: saturating count of hazard bubbles.

## Operation
- Hazard detection (combinational): `hazard_stall = id_valid & ex_valid & ex_m_ctl[1] & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt)`.
- Each rising `clk` edge updates the stage under a fixed priority:
  1. `flush`: the stage becomes a bubble.
  2. `stall`: all registers, including `bubble_cnt`, hold.
  3. `hazard_stall`: the stage becomes a bubble and `bubble_cnt` increments.
  4. `id_valid = 0`: the stage becomes a bubble.
  5. Otherwise: every `id_*` field loads and `ex_valid <= 1`.
- A bubble forces `ex_valid`, `ex_wb_ctl`, `ex_m_ctl`, `ex_ex_ctl`, `ex_a`, `ex_b`, `ex_imm`, `ex_pc4`, `ex_rs`, `ex_rt` and `ex_rd` all to 0.
- A bubble never writes a register or memory, because its control fields are 0.
- `bubble_cnt` saturates at 0xFFFF and does not wrap.
- Flush plus hazard in the same cycle: the flush wins and `bubble_cnt` does not increment.
- Stall plus hazard in the same cycle: the stage holds. The hazard stays asserted because the EX-stage state is unchanged; the bubble is inserted once the stall releases.
- A load targeting `$0` never raises a hazard.

## Timing
- Latency is 1 cycle from the `id_*` inputs to the `ex_*` outputs.
- `hazard_stall` is valid in the same cycle and is derived from the current `ex_*` registers and the `id_rs`/`id_rt` inputs.
- A load-use sequence yields exactly one bubble. In the next cycle `ex_m_ctl[1] = 0`, so the hazard drops.
- Asserting `rst_n = 0` clears all outputs to 0 immediately, without waiting for `clk`, and `bubble_cnt` becomes 0. Reset mid-stall or mid-hazard discards the held instruction.
- After reset is released, the first real instruction appears on the `ex_*` outputs one edge after it is presented with `id_valid = 1`.

## Configuration
- `ID_EX_FWD_EN` defined: on load, writeback data bypasses the register file.
  - `ex_a <= wb_data` when `wb_regwrite & wb_rd != 0 & wb_rd == id_rs`.
  - `ex_b` is bypassed the same way against `id_rt`.
  - This closes the same-cycle write/read gap in the register file.
- `ID_EX_FWD_EN` undefined: `ex_a`/`ex_b` always load `id_a`/`id_b`, and the `wb_*` ports are ignored.

## Test plan
- **Reset and load:** hold `rst_n = 0` mid-cycle; all outputs must be 0 asynchronously. Release, then present `id_valid = 1`, `id_a = 0x11`, `id_b = 0x22`, `id_rd = 5`, `id_wb_ctl = 2'b10`; the next edge must show `ex_valid = 1`, `ex_a = 0x11`, `ex_b = 0x22`, `ex_rd = 5`.
- **Load-use:** `lw $8` in EX (`ex_m_ctl = 3'b010`, `ex_rt = 8`) with `id_rs = 8`. `hazard_stall` must be 1; the next edge must be a bubble with `bubble_cnt = 1`; the following cycle `hazard_stall` must be 0. Repeat with `ex_rt = 0`: no hazard.
- **Stall then flush:** with a loaded instruction, `stall = 1` for 3 cycles must leave all outputs unchanged. Then `flush = 1` together with a hazard present must produce a bubble and leave `bubble_cnt` unchanged.
- **Stall and hazard together:** `stall = 1` while `hazard_stall = 1` must hold the stage and leave `bubble_cnt` unchanged. Releasing the stall must insert exactly one bubble and increment `bubble_cnt` once.
- **Saturation:** force 65 536 hazard bubbles; `bubble_cnt` must stay at 0xFFFF.
- **Forwarding (with `ID_EX_FWD_EN`):** `wb_regwrite = 1`, `wb_rd = 3`, `wb_data = 0xDEAD`, `id_rs = 3`, `id_a = 0` must give `ex_a = 0xDEAD`. The same stimulus with `wb_rd = 0` must give `ex_a = 0`. Without the macro, `ex_a = 0` in both cases.
